// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adder_pkg
//  Description : Shared types and defaults for the dynamic-adder requester.
//  Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

    localparam int c_width    = 32;
    localparam int c_max_wait = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } req_state_t;

endpackage
`default_nettype wire

// File: rtl/adder_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : adder_wait_counter
//  Description : Latency counter for one adder operation with timeout flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_wait_counter #(
    parameter int MAX_WAIT = 64,
    parameter int LAT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [LAT_W-1:0] count,
    output logic             timeout
);

    localparam logic [LAT_W-1:0] c_last = LAT_W'(MAX_WAIT - 1);

    logic [LAT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + LAT_W'(1);
        end
    end

    assign count   = r_count;
    assign timeout = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/adder_requester.sv
`default_nettype none
// ============================================================================
//  Module      : adder_requester
//  Description : Launches operand pairs into the dynamic adder, waits for
//                completion (with watchdog) and offers the registered result.
//  Revision    : 1.0 - initial release
// ============================================================================
module adder_requester
    import adder_pkg::*;
#(
    parameter int WIDTH    = c_width,
    parameter int MAX_WAIT = c_max_wait,
    parameter int LAT_W    = $clog2(MAX_WAIT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    output logic             add_first,
    output logic             add_request,
    input  logic             add_done,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [LAT_W-1:0] out_lat,
    output logic             out_err
);

    req_state_t       r_state;
    req_state_t       w_state_next;
    logic             w_accept;
    logic             w_done_hit;
    logic             w_timeout_hit;
    logic [LAT_W-1:0] w_count;
    logic             w_timeout;

    logic             r_in_ready;
    logic [WIDTH-1:0] r_add_a;
    logic [WIDTH-1:0] r_add_b;
    logic             r_add_cin;
    logic             r_add_first;
    logic             r_add_request;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_cout;
    logic [LAT_W-1:0] r_out_lat;
    logic             r_out_err;

    adder_wait_counter #(
        .MAX_WAIT (MAX_WAIT),
        .LAT_W    (LAT_W)
    ) u_wait_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (r_state == LAUNCH),
        .en      (r_state == WAIT),
        .count   (w_count),
        .timeout (w_timeout)
    );

    // add_done is only meaningful in WAIT; in LAUNCH the adder timer is still being reset.
    assign w_accept      = (r_state == IDLE) && in_valid && r_in_ready;
    assign w_done_hit    = (r_state == WAIT) && add_done;
    assign w_timeout_hit = (r_state == WAIT) && !add_done && w_timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = LAUNCH;
            LAUNCH:  w_state_next = WAIT;
            WAIT:    if (w_done_hit || w_timeout_hit) w_state_next = HOLD;
            HOLD:    if (r_out_valid && out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Handshake/strobe outputs are decoded from the next state so they are pure flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_ready    <= 1'b1;
            r_add_first   <= 1'b0;
            r_add_request <= 1'b0;
            r_out_valid   <= 1'b0;
            r_add_a       <= '0;
            r_add_b       <= '0;
            r_add_cin     <= 1'b0;
            r_out_sum     <= '0;
            r_out_cout    <= 1'b0;
            r_out_lat     <= '0;
            r_out_err     <= 1'b0;
        end else begin
            r_in_ready    <= (w_state_next == IDLE);
            r_add_first   <= (w_state_next == LAUNCH);
            r_add_request <= (w_state_next == LAUNCH) || (w_state_next == WAIT);
            r_out_valid   <= (w_state_next == HOLD);
            if (w_accept) begin
                r_add_a   <= in_a;
                r_add_b   <= in_b;
                r_add_cin <= in_cin;
            end
            if (w_done_hit) begin
                r_out_sum  <= add_sum;
                r_out_cout <= add_cout;
                r_out_lat  <= w_count + LAT_W'(1);
                r_out_err  <= 1'b0;
            end else if (w_timeout_hit) begin
                r_out_sum  <= '0;
                r_out_cout <= 1'b0;
                r_out_lat  <= LAT_W'(MAX_WAIT);
                r_out_err  <= 1'b1;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign add_a       = r_add_a;
    assign add_b       = r_add_b;
    assign add_cin     = r_add_cin;
    assign add_first   = r_add_first;
    assign add_request = r_add_request;
    assign out_valid   = r_out_valid;
    assign out_sum     = r_out_sum;
    assign out_cout    = r_out_cout;
    assign out_lat     = r_out_lat;
    assign out_err     = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_adder_requester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adder_requester
//  Description : Self-checking bench for adder_requester with a behavioural
//                dynamic-adder model and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_requester;

    localparam int WIDTH    = 32;
    localparam int MAX_WAIT = 64;
    localparam int LAT_W    = $clog2(MAX_WAIT + 1);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic             add_first;
    logic             add_request;
    logic             add_done;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic [LAT_W-1:0] out_lat;
    logic             out_err;

    adder_requester #(
        .WIDTH    (WIDTH),
        .MAX_WAIT (MAX_WAIT),
        .LAT_W    (LAT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_cin      (in_cin),
        .add_a       (add_a),
        .add_b       (add_b),
        .add_cin     (add_cin),
        .add_first   (add_first),
        .add_request (add_request),
        .add_done    (add_done),
        .add_sum     (add_sum),
        .add_cout    (add_cout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_cout    (out_cout),
        .out_lat     (out_lat),
        .out_err     (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        int               k;       // adder latency in cycles; -1 means never done
        logic             glitch;  // spurious done during the launch cycle
        int               hold;    // cycles of out_ready=0 in HOLD
    } vec_t;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic [LAT_W-1:0] lat;
        logic             err;
    } exp_t;

    int   checks;
    int   failures;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic run_op(input vec_t v);
        logic [WIDTH:0]   full;
        exp_t             e;
        exp_t             got;
        int               eff_k;
        int               seen;
        int               first_extra;
        logic [WIDTH-1:0] snap_sum;
        logic [LAT_W-1:0] snap_lat;

        full  = {1'b0, v.a} + {1'b0, v.b} + {{WIDTH{1'b0}}, v.cin};
        eff_k = (v.k < 0) ? MAX_WAIT : v.k;
        e.err  = (v.k < 0);
        e.sum  = e.err ? '0 : full[WIDTH-1:0];
        e.cout = e.err ? 1'b0 : full[WIDTH];
        e.lat  = LAT_W'(eff_k);

        // present operands in IDLE
        check("start_in_ready", 64'(in_ready), 64'd1);
        out_ready = (v.hold == 0);
        in_a      = v.a;
        in_b      = v.b;
        in_cin    = v.cin;
        in_valid  = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);

        // LAUNCH cycle
        in_valid = 1'b0;
        in_a     = ~v.a;
        in_b     = ~v.b;
        check("launch_first", 64'(add_first), 64'd1);
        check("launch_request", 64'(add_request), 64'd1);
        check("launch_operands", {31'd0, add_cin, add_a}, {31'd0, v.cin, v.a});
        if (v.glitch) begin
            add_done = 1'b1;
            add_sum  = 32'hDEAD_BEEF;
            add_cout = 1'b1;
        end

        seen        = 0;
        first_extra = 0;
        for (int j = 1; j <= MAX_WAIT + 10; j++) begin
            @(negedge clk);
            add_done = 1'b0;
            add_sum  = ~full[WIDTH-1:0];
            add_cout = ~full[WIDTH];
            if (out_valid) begin
                seen = j;
                break;
            end
            if (add_first) first_extra++;
            if (!add_request) first_extra++;
            if (j == v.k) begin
                add_done = 1'b1;
                add_sum  = full[WIDTH-1:0];
                add_cout = full[WIDTH];
            end
        end
        check("first_one_cycle_request_held", 64'(first_extra), 64'd0);
        check("out_valid_timing", 64'(seen), 64'(eff_k + 1));
        check("no_request_in_hold", 64'(add_request), 64'd0);

        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
            e   = sb_q.pop_front();
            got = '{sum: out_sum, cout: out_cout, lat: out_lat, err: out_err};
            check("result_sum", 64'(got.sum), 64'(e.sum));
            check("result_cout_lat_err", {56'd0, got.cout, got.lat},
                  {56'd0, e.cout, e.lat});
            check("result_err", 64'(got.err), 64'(e.err));
        end

        // backpressure: a pending input must not be accepted and the result must stay put
        snap_sum = out_sum;
        snap_lat = out_lat;
        for (int h = 0; h < v.hold; h++) begin
            in_valid = 1'b1;
            in_a     = 32'h5555_AAAA;
            @(negedge clk);
            check("bp_stable", {31'd0, out_valid, out_sum}, {31'd0, 1'b1, snap_sum});
            check("bp_lat_in_ready", {56'd0, in_ready, out_lat}, {56'd0, 1'b0, snap_lat});
            check("bp_no_accept", 64'(add_a), 64'(v.a));
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("handshake_idle", {62'd0, out_valid, in_ready}, 64'd1);
    endtask

    vec_t vecs[7];

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        add_done  = 1'b0;
        add_sum   = '0;
        add_cout  = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{a: 32'h0000_0003, b: 32'h0000_0005, cin: 1'b0, k: 3,  glitch: 1'b0, hold: 0};
        vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'h0000_0001, cin: 1'b0, k: 30, glitch: 1'b0, hold: 0};
        vecs[2] = '{a: 32'h1111_2222, b: 32'h3333_4444, cin: 1'b1, k: -1, glitch: 1'b0, hold: 0};
        vecs[3] = '{a: 32'h1234_5678, b: 32'h9ABC_DEF0, cin: 1'b1, k: 5,  glitch: 1'b0, hold: 10};
        vecs[4] = '{a: 32'h0000_0007, b: 32'h0000_0008, cin: 1'b1, k: 2,  glitch: 1'b1, hold: 0};
        vecs[5] = '{a: 32'h8000_0000, b: 32'h8000_0000, cin: 1'b1, k: 1,  glitch: 1'b0, hold: 0};
        vecs[6] = '{a: 32'hCAFE_0001, b: 32'h0000_FFFF, cin: 1'b0, k: MAX_WAIT, glitch: 1'b0, hold: 0};

        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_outputs", {58'd0, out_valid, add_first, add_request, out_err, out_cout, add_cin},
              64'd0);
        check("reset_data", {out_sum, add_a}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {62'd0, in_ready, out_valid}, 64'd2);

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i]);
        end

        // mid-WAIT reset
        in_a     = 32'h0000_0010;
        in_b     = 32'h0000_0020;
        in_cin   = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("midwait_request", 64'(add_request), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midwait_rst_outputs", {61'd0, add_request, out_valid, in_ready}, 64'd1);
        @(negedge clk);
        check("midwait_idle_after", {62'd0, in_ready, add_request}, 64'd2);
        run_op('{a: 32'h0000_0010, b: 32'h0000_0020, cin: 1'b0, k: 4, glitch: 1'b0, hold: 0});

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // in_ready and out_valid are mutually exclusive at all times
    always @(negedge clk) begin
        if (rst_n && in_ready && out_valid) begin
            check("ready_valid_exclusive", 64'd1, 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire
